// File: rtl/delay_timer_bank.sv
// delay_timer_bank: bank of independent one-shot/periodic delay timers with pause and live length.
// Optional shared prescaler enabled by defining DELAY_TIMER_PRESCALE_EN.
module delay_timer_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
`ifdef DELAY_TIMER_PRESCALE_EN
    ,
    parameter int PRESCALE = 1000
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS-1:0]       hold,
    input  logic [CHANNELS*WIDTH-1:0] len,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       busy,
    output logic                      any_done
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    logic tick;
`ifdef DELAY_TIMER_PRESCALE_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;
    assign tick = pre == PW'(PRESCALE - 1);
    always_ff @(posedge clk) begin
        if (reset) pre <= '0;
        else       pre <= tick ? '0 : pre + 1'b1;
    end
`else
    assign tick = 1'b1;
`endif
    assign any_done = |done;
    for (genvar i = 0; i < CHANNELS; i++) begin : ch
        state_t           state, state_n;
        logic [WIDTH-1:0] cnt, cnt_n, lim;
        logic             done_n;
        assign lim = len[i*WIDTH +: WIDTH];
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            done_n  = 1'b0;
            if (!enable[i]) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (state == IDLE) begin
                state_n = RUN;
                cnt_n   = '0;
            end else if (state == RUN) begin
                // hold and non-tick cycles both freeze; compare is >= so a lowered len expires at once
                if (!hold[i] && tick) begin
                    done_n  = cnt >= lim;
                    cnt_n   = done_n ? '0 : cnt + 1'b1;
                    state_n = (done_n && !periodic[i]) ? EXPIRED : RUN;
                end
            end else begin
                cnt_n = '0;
            end
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= IDLE;
                cnt     <= '0;
                done[i] <= 1'b0;
                busy[i] <= 1'b0;
            end else begin
                state   <= state_n;
                cnt     <= cnt_n;
                done[i] <= done_n;
                busy[i] <= state_n == RUN;
            end
        end
        assign count[i*WIDTH +: WIDTH] = cnt;
    end
endmodule

// File: tb/tb_delay_timer_bank.sv
// tb_delay_timer_bank: directed self-checking bench for delay_timer_bank (default build, no prescaler).
module tb_delay_timer_bank;
    logic         clk, reset;
    logic [3:0]   enable, periodic, hold, done, busy;
    logic [127:0] len, count;
    logic         any_done;
    int           tests = 0;
    int           fails = 0;

    delay_timer_bank #(.WIDTH(32), .CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .periodic(periodic), .hold(hold),
        .len(len), .count(count), .done(done), .busy(busy), .any_done(any_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = '0; periodic = '0; hold = '0; len = '0;
        step(); step();
        check("reset_count", count[31:0] | count[63:32] | count[95:64] | count[127:96], 32'd0);
        check("reset_done", {28'd0, done}, 32'd0);
        check("reset_busy", {28'd0, busy}, 32'd0);
        check("reset_any", {31'd0, any_done}, 32'd0);
        reset = 1'b0;

        // channel 0 one-shot, len=5
        len[31:0] = 32'd5; enable[0] = 1'b1;
        step();
        check("c0_e0_count", count[31:0], 32'd0);
        check("c0_e0_busy", {31'd0, busy[0]}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("c0_run_count", count[31:0], k);
            check("c0_run_done", {31'd0, done[0]}, 32'd0);
        end
        step();
        check("c0_e6_done", {31'd0, done[0]}, 32'd1);
        check("c0_e6_any", {31'd0, any_done}, 32'd1);
        check("c0_e6_count", count[31:0], 32'd0);
        check("c0_e6_busy", {31'd0, busy[0]}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("c0_exp_done", {31'd0, done[0]}, 32'd0);
            check("c0_exp_count", count[31:0], 32'd0);
            check("c0_exp_busy", {31'd0, busy[0]}, 32'd0);
        end
        enable[0] = 1'b0;
        step();

        // channel 0 periodic, len=0: done continuously from E1
        len[31:0] = 32'd0; periodic[0] = 1'b1; enable[0] = 1'b1;
        step();
        check("c0_len0_e0_done", {31'd0, done[0]}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("c0_len0_done", {31'd0, done[0]}, 32'd1);
        end
        enable[0] = 1'b0; periodic[0] = 1'b0;
        step();
        check("c0_off_done", {31'd0, done[0]}, 32'd0);

        // channel 1 periodic, len=3
        len[63:32] = 32'd3; periodic[1] = 1'b1; enable[1] = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            check("c1_count", count[63:32], k % 4);
            check("c1_done", {31'd0, done[1]}, (k > 0 && k % 4 == 0) ? 32'd1 : 32'd0);
            check("c1_busy", {31'd0, busy[1]}, 32'd1);
        end
        enable[1] = 1'b0; periodic[1] = 1'b0;
        step();

        // channel 2 len=10 with a 4-edge hold after E3
        len[95:64] = 32'd10; enable[2] = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            step();
            check("c2_count", count[95:64], k <= 3 ? k : k <= 7 ? 3 : k <= 14 ? k - 4 : 0);
            check("c2_done", {31'd0, done[2]}, k == 15 ? 32'd1 : 32'd0);
            hold[2] = (k >= 3 && k < 7);
        end
        enable[2] = 1'b0;
        step();

        // channel 3 len=20, lowered to 8 at count 12
        len[127:96] = 32'd20; enable[3] = 1'b1;
        for (int k = 0; k <= 12; k++) step();
        check("c3_count12", count[127:96], 32'd12);
        len[127:96] = 32'd8;
        step();
        check("c3_lower_done", {31'd0, done[3]}, 32'd1);
        check("c3_lower_count", count[127:96], 32'd0);
        check("c3_lower_busy", {31'd0, busy[3]}, 32'd0);
        enable[3] = 1'b0;
        step();

        // channel 3 enable dropped on the expiry edge: no done
        len[127:96] = 32'd2; enable[3] = 1'b1;
        step(); step(); step();
        check("c3_pre_count", count[127:96], 32'd2);
        enable[3] = 1'b0;
        step();
        check("c3_drop_done", {31'd0, done[3]}, 32'd0);
        check("c3_drop_count", count[127:96], 32'd0);
        step();
        check("c3_drop_done2", {31'd0, done[3]}, 32'd0);

        // hold on the terminal edge wins
        len[31:0] = 32'd1; enable[0] = 1'b1;
        step(); step();
        hold[0] = 1'b1;
        step();
        check("hold_term_done", {31'd0, done[0]}, 32'd0);
        check("hold_term_count", count[31:0], 32'd1);
        hold[0] = 1'b0;
        step();
        check("hold_rel_done", {31'd0, done[0]}, 32'd1);
        enable[0] = 1'b0;
        step();

        // all channels running, reset mid-run
        len = {4{32'd100}}; enable = 4'hf;
        for (int k = 0; k < 6; k++) step();
        check("all_run_count", count[95:64], 32'd5);
        reset = 1'b1;
        step();
        check("mid_reset_count", count[31:0] | count[63:32] | count[95:64] | count[127:96], 32'd0);
        check("mid_reset_done", {28'd0, done}, 32'd0);
        check("mid_reset_busy", {28'd0, busy}, 32'd0);
        check("mid_reset_any", {31'd0, any_done}, 32'd0);
        reset = 1'b0;
        step();
        check("post_reset_busy", {28'd0, busy}, 32'hf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
